// File: rtl/sr_cmd_sequencer.sv
// Command front-end for an SR flop: queues set/clear/toggle/hold commands
// and replays them as registered s/r levels while shadowing the flop's Q.
module sr_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 4,
    parameter bit GAP_EN = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [CNT_W-1:0]       in_len,
    output logic                   s,
    output logic                   r,
    output logic                   q_model,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             s_n;
    logic             r_n;
    logic             q_n;

    logic [1:0]       op_mem  [DEPTH];
    logic [CNT_W-1:0] len_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             take;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;
    logic [CNT_W-1:0] load_cnt;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;

    assign head_op  = op_mem[rd_ptr];
    assign head_len = len_mem[rd_ptr];
    // A zero length still drives for one cycle.
    assign load_cnt = (head_len == '0) ? '0 : head_len - CNT_W'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        s_n     = s;
        r_n     = r;
        take    = 1'b0;
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            s_n     = 1'b0;
            r_n     = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    s_n = 1'b0;
                    r_n = 1'b0;
                    if (!empty) take = 1'b1;
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else if (GAP_EN) begin
                        state_n = GAP;
                        s_n     = 1'b0;
                        r_n     = 1'b0;
                    end else if (!empty) begin
                        take = 1'b1;
                    end else begin
                        state_n = IDLE;
                        s_n     = 1'b0;
                        r_n     = 1'b0;
                    end
                end
                GAP: begin
                    s_n = 1'b0;
                    r_n = 1'b0;
                    if (!empty) take = 1'b1;
                    else state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    s_n     = 1'b0;
                    r_n     = 1'b0;
                end
            endcase
        end
        if (take) begin
            state_n = DRIVE;
            cnt_n   = load_cnt;
            s_n     = head_op[1];
            r_n     = head_op[0];
        end
    end

    assign pop = take;

    // Shadow of the downstream flop, fed by the levels it sees this cycle.
    always_comb begin
        q_n = q_model;
        unique case ({s, r})
            2'b00: q_n = q_model;
            2'b01: q_n = 1'b0;
            2'b10: q_n = 1'b1;
            2'b11: q_n = ~q_model;
            default: q_n = q_model;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            s       <= 1'b0;
            r       <= 1'b0;
            q_model <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            s       <= s_n;
            r       <= r_n;
            q_model <= q_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_mem[i]  <= '0;
                len_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                op_mem[wr_ptr]  <= in_op;
                len_mem[wr_ptr] <= in_len;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    assign fifo_level = level;
    assign busy       = (state != IDLE) || !empty;

endmodule
